// File: rtl/rv_clint.sv
// rv_clint: core-local interruptor. Holds the 64-bit mtime counter with its
// prescaler, the per-hart mtimecmp and msip registers, and serves 32-bit
// word-aligned MMIO reads and writes with one cycle of read latency.
`timescale 1ns/1ps
module rv_clint #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  input  logic               w_we,
  input  logic               w_re,
  output logic [31:0]        r_rdata,
  output logic               r_rvalid,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [13:0]   MTIME_LO_W = 14'h2FFE;
  localparam logic [13:0]   MTIME_HI_W = 14'h2FFF;
  localparam logic [13:0]   CMP_BASE_W = 14'h1000;

  logic [PW-1:0]      presc;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp [N_HARTS];
  logic [N_HARTS-1:0] msip;
  logic [N_HARTS-1:0] mtip;

  logic [13:0]        word;
  logic               tick;
  logic               rd_go;
  logic               sel_mtime_lo;
  logic               sel_mtime_hi;
  logic [N_HARTS-1:0] sel_msip;
  logic [N_HARTS-1:0] sel_cmp_lo;
  logic [N_HARTS-1:0] sel_cmp_hi;
  logic [31:0]        rd_val;
  logic               unused_addr_bits;

  // Byte-lane bits are ignored: every access is a full word.
  assign word             = w_addr[15:2];
  assign unused_addr_bits = ^w_addr[1:0];
  assign tick             = (presc == PRESC_MAX);
  // A simultaneous write wins; the read is dropped.
  assign rd_go            = w_re & ~w_we;

  // Address decode and read-data mux; unmapped offsets read as zero.
  always_comb begin
    sel_mtime_lo = (word == MTIME_LO_W);
    sel_mtime_hi = (word == MTIME_HI_W);
    sel_msip     = '0;
    sel_cmp_lo   = '0;
    sel_cmp_hi   = '0;
    rd_val       = '0;
    if (sel_mtime_lo) rd_val = mtime[31:0];
    if (sel_mtime_hi) rd_val = mtime[63:32];
    for (int h = 0; h < N_HARTS; h++) begin
      sel_msip[h]   = (word == 14'(h));
      sel_cmp_lo[h] = (word == CMP_BASE_W + 14'(2 * h));
      sel_cmp_hi[h] = (word == CMP_BASE_W + 14'(2 * h + 1));
      if (sel_msip[h])   rd_val = {31'b0, msip[h]};
      if (sel_cmp_lo[h]) rd_val = mtimecmp[h][31:0];
      if (sel_cmp_hi[h]) rd_val = mtimecmp[h][63:32];
    end
  end

  // mtime and prescaler; a write to either half replaces the tick for that
  // cycle (no carry into the other half) and restarts the tick period.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      mtime <= '0;
      presc <= '0;
    end else if (w_we && sel_mtime_lo) begin
      mtime <= {mtime[63:32], w_wdata};
      presc <= '0;
    end else if (w_we && sel_mtime_hi) begin
      mtime <= {w_wdata, mtime[31:0]};
      presc <= '0;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Per-hart msip and mtimecmp write ports.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      msip <= '0;
      for (int h = 0; h < N_HARTS; h++) mtimecmp[h] <= '1;
    end else if (w_we) begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (sel_msip[h])   msip[h]            <= w_wdata[0];
        if (sel_cmp_lo[h]) mtimecmp[h][31:0]  <= w_wdata;
        if (sel_cmp_hi[h]) mtimecmp[h][63:32] <= w_wdata;
      end
    end
  end

  // Timer-pending compare on current register values, so it trails changes by one cycle.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      mtip <= '0;
    end else begin
      for (int h = 0; h < N_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
    end
  end

  // Registered read response; data holds until the next accepted read.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= rd_go;
      if (rd_go) r_rdata <= rd_val;
    end
  end

  assign w_mtime = mtime;
  assign w_mtip  = mtip;
  assign w_msip  = msip;

endmodule

// File: tb/tb_rv_clint.sv
// Bench for rv_clint: two instances share one bus. Instance a has two harts
// and ticks every cycle; instance b has one hart and ticks every fourth cycle.
`timescale 1ns/1ps
module tb_rv_clint;

  logic        CLK;
  logic        RST_X;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_re;

  logic [31:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
  logic [63:0] a_mtime, b_mtime;
  logic [1:0]  a_mtip, a_msip;
  logic        b_mtip, b_msip;

  rv_clint #(.N_HARTS(2), .TICK_DIV(1)) dut_a (
    .CLK(CLK), .RST_X(RST_X), .w_addr(w_addr), .w_wdata(w_wdata), .w_we(w_we), .w_re(w_re),
    .r_rdata(a_rdata), .r_rvalid(a_rvalid), .w_mtime(a_mtime), .w_mtip(a_mtip), .w_msip(a_msip)
  );

  rv_clint #(.N_HARTS(1), .TICK_DIV(4)) dut_b (
    .CLK(CLK), .RST_X(RST_X), .w_addr(w_addr), .w_wdata(w_wdata), .w_we(w_we), .w_re(w_re),
    .r_rdata(b_rdata), .r_rvalid(b_rvalid), .w_mtime(b_mtime), .w_mtip(b_mtip), .w_msip(b_msip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: index 0 is instance a, index 1 is instance b.
  logic [63:0] m_mtime  [2];
  int          m_presc  [2];
  logic [63:0] m_cmp    [2][2];
  logic [1:0]  m_msip   [2];
  logic [1:0]  m_mtip   [2];
  logic [31:0] m_rdata  [2];
  logic        m_rvalid [2];

  function automatic int n_harts(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int tick_div(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] m_read(int i, int off);
    int h;
    if (off < 4 * n_harts(i)) return {31'b0, m_msip[i][off / 4]};
    if (off >= 'h4000 && off < 'h4000 + 8 * n_harts(i)) begin
      h = (off - 'h4000) / 8;
      return (off % 8 == 0) ? m_cmp[i][h][31:0] : m_cmp[i][h][63:32];
    end
    if (off == 'hBFF8) return m_mtime[i][31:0];
    if (off == 'hBFFC) return m_mtime[i][63:32];
    return 32'h0;
  endfunction

  function automatic void m_step(int i);
    int          off;
    int          h;
    logic [63:0] nxt;
    logic [1:0]  pend;
    off  = int'({w_addr[15:2], 2'b00});
    pend = 2'b00;
    for (int k = 0; k < n_harts(i); k++) pend[k] = (m_mtime[i] >= m_cmp[i][k]);
    m_rvalid[i] = w_re && !w_we;
    if (w_re && !w_we) m_rdata[i] = m_read(i, off);
    nxt = m_mtime[i];
    if (m_presc[i] == tick_div(i) - 1) begin
      nxt = nxt + 1;
      m_presc[i] = 0;
    end else begin
      m_presc[i] = m_presc[i] + 1;
    end
    if (w_we) begin
      if (off < 4 * n_harts(i)) begin
        m_msip[i][off / 4] = w_wdata[0];
      end else if (off >= 'h4000 && off < 'h4000 + 8 * n_harts(i)) begin
        h = (off - 'h4000) / 8;
        if (off % 8 == 0) m_cmp[i][h][31:0] = w_wdata;
        else              m_cmp[i][h][63:32] = w_wdata;
      end else if (off == 'hBFF8) begin
        nxt = {m_mtime[i][63:32], w_wdata};
        m_presc[i] = 0;
      end else if (off == 'hBFFC) begin
        nxt = {w_wdata, m_mtime[i][31:0]};
        m_presc[i] = 0;
      end
    end
    m_mtime[i] = nxt;
    m_mtip[i]  = pend;
  endfunction

  always @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int i = 0; i < 2; i++) begin
        m_mtime[i]  = '0;
        m_presc[i]  = 0;
        m_cmp[i][0] = '1;
        m_cmp[i][1] = '1;
        m_msip[i]   = '0;
        m_mtip[i]   = '0;
        m_rdata[i]  = '0;
        m_rvalid[i] = 1'b0;
      end
    end else begin
      m_step(0);
      m_step(1);
    end
  end

  // Every cycle, away from the active edge, both DUTs against the model.
  always @(negedge CLK) begin
    chk("a_mtime",  a_mtime,  m_mtime[0]);
    chk("a_mtip",   a_mtip,   m_mtip[0]);
    chk("a_msip",   a_msip,   m_msip[0]);
    chk("a_rvalid", a_rvalid, m_rvalid[0]);
    chk("a_rdata",  a_rdata,  m_rdata[0]);
    chk("b_mtime",  b_mtime,  m_mtime[1]);
    chk("b_mtip",   b_mtip,   m_mtip[1][0]);
    chk("b_msip",   b_msip,   m_msip[1][0]);
    chk("b_rvalid", b_rvalid, m_rvalid[1]);
    chk("b_rdata",  b_rdata,  m_rdata[1]);
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge CLK);
    w_addr  = a;
    w_wdata = d;
    w_we    = 1'b1;
    @(negedge CLK);
    w_we    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge CLK);
    w_addr = a;
    w_re   = 1'b1;
    @(negedge CLK);
    w_re   = 1'b0;
  endtask

  logic found;

  initial begin
    RST_X   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    w_re    = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_a_mtime",  a_mtime,  64'd0);
    chk("rst_a_mtip",   a_mtip,   2'b00);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rdata",  b_rdata,  32'd0);
    RST_X = 1'b1;

    // Prescaled tick: 40 cycles at divide-by-4.
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    chk("b_mtime_40cyc", b_mtime, 64'd10);
    chk("a_mtime_40cyc", a_mtime, 64'd40);
    wr(16'hBFF8, 32'd5);
    chk("b_mtime_wr5", b_mtime, 64'd5);
    chk("a_mtime_wr5", a_mtime, 64'd5);

    // Timer compare on hart 0.
    wr(16'h4004, 32'hFFFF_FFFF);
    wr(16'h4000, 32'd20);
    wr(16'h4004, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK);
      if (a_mtime == 64'd20) found = 1'b1;
    end
    chk("a_mtime_reaches_20", found, 1'b1);
    chk("a_mtip_at_20", a_mtip[0], 1'b0);
    @(negedge CLK);
    chk("a_mtip_after_20", a_mtip[0], 1'b1);
    wr(16'h4004, 32'd1);
    chk("a_mtip_1_after_hi", a_mtip[0], 1'b1);
    @(negedge CLK);
    chk("a_mtip_2_after_hi", a_mtip[0], 1'b0);

    // Wrap of mtime through all-ones.
    wr(16'h4000, 32'hFFFF_FFFF);
    wr(16'h4004, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    chk("a_mtime_fe", a_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge CLK);
    chk("a_mtime_ff", a_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("a_mtip_pre_wrap", a_mtip[0], 1'b0);
    @(negedge CLK);
    chk("a_mtime_wrap", a_mtime, 64'd0);
    chk("a_mtip_at_wrap", a_mtip[0], 1'b1);
    @(negedge CLK);
    chk("a_mtip_post_wrap", a_mtip[0], 1'b0);

    // msip mapping and out-of-range hart slots.
    wr(16'h0004, 32'hFFFF_FFFF);
    chk("a_msip_h1", a_msip, 2'b10);
    chk("b_msip_h1_ignored", b_msip, 1'b0);
    rd(16'h0004);
    chk("a_rd_msip1_valid", a_rvalid, 1'b1);
    chk("a_rd_msip1", a_rdata, 32'd1);
    chk("b_rd_msip1", b_rdata, 32'd0);
    wr(16'h0008, 32'd1);
    chk("a_msip_h2_ignored", a_msip, 2'b10);
    rd(16'h0008);
    chk("a_rd_0008", a_rdata, 32'd0);
    rd(16'h0006);
    chk("a_rd_0006_alias", a_rdata, 32'd1);

    // Write and read in the same cycle: write wins, no response.
    @(negedge CLK);
    w_addr  = 16'h0000;
    w_wdata = 32'd1;
    w_we    = 1'b1;
    w_re    = 1'b1;
    @(negedge CLK);
    w_we    = 1'b0;
    w_re    = 1'b0;
    chk("a_msip_collide", a_msip, 2'b11);
    chk("a_rvalid_collide", a_rvalid, 1'b0);

    // Reset lands while a read strobe is pending.
    @(negedge CLK);
    w_addr = 16'h4000;
    w_re   = 1'b1;
    #2 RST_X = 1'b0;
    @(negedge CLK);
    w_re = 1'b0;
    chk("rst_rvalid", a_rvalid, 1'b0);
    chk("rst_mtime",  a_mtime,  64'd0);
    chk("rst_msip",   a_msip,   2'b00);
    chk("rst_rdata",  a_rdata,  32'd0);
    @(negedge CLK);
    RST_X = 1'b1;
    rd(16'h4004);
    chk("rst_a_cmp_hi", a_rdata, 32'hFFFF_FFFF);
    chk("rst_b_cmp_hi", b_rdata, 32'hFFFF_FFFF);
    rd(16'h4008);
    chk("rst_a_cmp1_lo", a_rdata, 32'hFFFF_FFFF);
    chk("rst_a_mtip", a_mtip, 2'b00);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
